// File: rtl/apu_pkg.sv
// Shared APU constants: length-counter lookup table, default frame-step times and frame mode type.
package apu_pkg;

   typedef enum logic {
      MODE_4STEP = 1'b0,
      MODE_5STEP = 1'b1
   } frame_mode_t;

   localparam int unsigned STEP_QF1    = 7457;
   localparam int unsigned STEP_QF2    = 14913;
   localparam int unsigned STEP_QF3    = 22371;
   localparam int unsigned STEP_QF4_M0 = 29829;
   localparam int unsigned STEP_QF4_M1 = 37281;

   localparam logic [7:0] LEN_TABLE [32] = '{
      8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
      8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
      8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
      8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
   };

   function automatic logic [7:0] len_lookup(input logic [4:0] idx);
      return LEN_TABLE[idx];
   endfunction

endpackage

// File: rtl/apu_frame_counter.sv
// APU frame sequencer: free-running step counter, quarter/half-frame pulses and frame IRQ.
// Frame IRQ logic is present only when TRI_FRAME_IRQ_EN is defined; otherwise irq is tied low.
module apu_frame_counter
   import apu_pkg::*;
#(
   parameter int unsigned QF1    = STEP_QF1,
   parameter int unsigned QF2    = STEP_QF2,
   parameter int unsigned QF3    = STEP_QF3,
   parameter int unsigned QF4_M0 = STEP_QF4_M0,
   parameter int unsigned QF4_M1 = STEP_QF4_M1
) (
   input  logic clk,
   input  logic reset,
   input  logic frame_wr,
   input  logic frame_mode,
   input  logic frame_inhibit,
   input  logic irq_ack,
   output logic qf,
   output logic hf,
   output logic irq
);

   localparam logic [15:0] S1    = 16'(QF1);
   localparam logic [15:0] S2    = 16'(QF2);
   localparam logic [15:0] S3    = 16'(QF3);
   localparam logic [15:0] S4_M0 = 16'(QF4_M0);
   localparam logic [15:0] S4_M1 = 16'(QF4_M1);

   frame_mode_t mode_q, mode_d;
   logic [15:0] fc_q, fc_d;
   logic [15:0] last_step;
   logic        qf_d, hf_d;

   // Pulses are decoded from the next count so they line up with the edge that loads the step.
   always_comb begin
      last_step = (mode_q == MODE_5STEP) ? S4_M1 : S4_M0;
      mode_d    = mode_q;
      fc_d      = (fc_q >= last_step) ? '0 : fc_q + 16'd1;
      qf_d      = (fc_d == S1) || (fc_d == S2) || (fc_d == S3) || (fc_d == last_step);
      hf_d      = (fc_d == S2) || (fc_d == last_step);
      if (frame_wr) begin
         mode_d = frame_mode_t'(frame_mode);
         fc_d   = '0;
         qf_d   = frame_mode;
         hf_d   = frame_mode;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q <= MODE_4STEP;
         fc_q   <= '0;
         qf     <= 1'b0;
         hf     <= 1'b0;
      end else begin
         mode_q <= mode_d;
         fc_q   <= fc_d;
         qf     <= qf_d;
         hf     <= hf_d;
      end
   end

`ifdef TRI_FRAME_IRQ_EN
   logic inhibit_q;
   logic irq_set, irq_clr;

   always_comb begin
      irq_set = !frame_wr && (mode_q == MODE_4STEP) && !inhibit_q && (fc_d == S4_M0);
      irq_clr = irq_ack || (frame_wr && frame_inhibit);
   end

   // Set has priority over a coincident acknowledge or inhibit write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inhibit_q <= 1'b0;
         irq       <= 1'b0;
      end else begin
         if (frame_wr) begin
            inhibit_q <= frame_inhibit;
         end
         if (irq_set) begin
            irq <= 1'b1;
         end else if (irq_clr) begin
            irq <= 1'b0;
         end
      end
   end
`else
   logic unused_irq_inputs;
   assign unused_irq_inputs = frame_inhibit ^ irq_ack;
   assign irq = 1'b0;
`endif

endmodule

// File: rtl/tri_frame_ctrl.sv
// Triangle channel frame controller: frame sequencer plus linear and length counters gating tri_channel.
// Frame IRQ is built only with TRI_FRAME_IRQ_EN defined (see apu_frame_counter).
module tri_frame_ctrl
   import apu_pkg::*;
#(
   parameter int unsigned QF1    = STEP_QF1,
   parameter int unsigned QF2    = STEP_QF2,
   parameter int unsigned QF3    = STEP_QF3,
   parameter int unsigned QF4_M0 = STEP_QF4_M0,
   parameter int unsigned QF4_M1 = STEP_QF4_M1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] r1,
   input  logic [7:0] r4,
   input  logic       r4_wr,
   input  logic [7:0] frame,
   input  logic       frame_wr,
   input  logic       chan_en,
   input  logic       irq_ack,
   output logic       qf,
   output logic       hf,
   output logic       irq,
   output logic       len_active,
   output logic       tri_en
);

   logic [7:0] length, length_d;
   logic [6:0] linear, linear_d;
   logic       reload, reload_d, reload_eff;
   logic       unused_bits;

   assign unused_bits = ^{r4[2:0], frame[5:0]};

   apu_frame_counter #(
      .QF1    (QF1),
      .QF2    (QF2),
      .QF3    (QF3),
      .QF4_M0 (QF4_M0),
      .QF4_M1 (QF4_M1)
   ) u_frame_counter (
      .clk           (clk),
      .reset         (reset),
      .frame_wr      (frame_wr),
      .frame_mode    (frame[7]),
      .frame_inhibit (frame[6]),
      .irq_ack       (irq_ack),
      .qf            (qf),
      .hf            (hf),
      .irq           (irq)
   );

   always_comb begin
      length_d = length;
      if (!chan_en) begin
         length_d = '0;
      end else if (r4_wr) begin
         length_d = len_lookup(r4[7:3]);
      end else if (hf && (length != '0) && !r1[7]) begin
         length_d = length - 8'd1;
      end

      // A write coinciding with qf sets the flag early enough to reload on that qf.
      reload_eff = reload | r4_wr;
      reload_d   = reload_eff;
      linear_d   = linear;
      if (qf) begin
         if (reload_eff) begin
            linear_d = r1[6:0];
         end else if (linear != '0) begin
            linear_d = linear - 7'd1;
         end
         if (!r1[7]) begin
            reload_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         length     <= '0;
         linear     <= '0;
         reload     <= 1'b0;
         tri_en     <= 1'b0;
         len_active <= 1'b0;
      end else begin
         length     <= length_d;
         linear     <= linear_d;
         reload     <= reload_d;
         tri_en     <= (length != '0) && (linear != '0);
         len_active <= (length != '0);
      end
   end

endmodule

// File: tb/tb_tri_frame_ctrl.sv
// Bench for tri_frame_ctrl: directed frame/counter vectors plus randomized traffic against a reference model.
// Expected irq follows TRI_FRAME_IRQ_EN.
module tb_tri_frame_ctrl;

   localparam int P_QF1    = 7457;
   localparam int P_QF2    = 14913;
   localparam int P_QF3    = 22371;
   localparam int P_QF4_M0 = 29829;
   localparam int P_QF4_M1 = 37281;
`ifdef TRI_FRAME_IRQ_EN
   localparam bit IRQ_FEAT = 1'b1;
`else
   localparam bit IRQ_FEAT = 1'b0;
`endif

   int len_ref [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                        12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] r1, r4, frame;
   logic       r4_wr, frame_wr, chan_en, irq_ack;
   logic       qf, hf, irq, len_active, tri_en;

   always #5 clk = ~clk;

   tri_frame_ctrl #(
      .QF1    (P_QF1),
      .QF2    (P_QF2),
      .QF3    (P_QF3),
      .QF4_M0 (P_QF4_M0),
      .QF4_M1 (P_QF4_M1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .r1         (r1),
      .r4         (r4),
      .r4_wr      (r4_wr),
      .frame      (frame),
      .frame_wr   (frame_wr),
      .chan_en    (chan_en),
      .irq_ack    (irq_ack),
      .qf         (qf),
      .hf         (hf),
      .irq        (irq),
      .len_active (len_active),
      .tri_en     (tri_en)
   );

   int total = 0;
   int bad   = 0;

   // Reference state: t counts edges since reset release or the last frame write.
   int t, m_len, m_lin;
   bit m_mode, m_inh, m_irq, m_qf, m_hf, m_flag, m_tri, m_act;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      t = 0; m_len = 0; m_lin = 0;
      m_mode = 0; m_inh = 0; m_irq = 0; m_qf = 0; m_hf = 0;
      m_flag = 0; m_tri = 0; m_act = 0;
   endtask

   task automatic model_edge();
      bit pq, ph_pulse, set, clr;
      int pl, plin, period, ph;
      pq = m_qf; ph_pulse = m_hf; pl = m_len; plin = m_lin;
      if (frame_wr) begin
         m_mode = frame[7];
         m_inh  = frame[6];
         t      = 0;
         m_qf   = frame[7];
         m_hf   = frame[7];
         set    = 0;
         clr    = irq_ack || frame[6];
      end else begin
         period = m_mode ? P_QF4_M1 + 1 : P_QF4_M0 + 1;
         t++;
         ph   = t % period;
         m_qf = (ph == P_QF1) || (ph == P_QF2) || (ph == P_QF3) || (ph == period - 1);
         m_hf = (ph == P_QF2) || (ph == period - 1);
         set  = !m_mode && !m_inh && (ph == P_QF4_M0);
         clr  = irq_ack;
      end
      if (!IRQ_FEAT) m_irq = 0;
      else if (set)  m_irq = 1;
      else if (clr)  m_irq = 0;

      if (!chan_en)                         m_len = 0;
      else if (r4_wr)                       m_len = len_ref[r4[7:3]];
      else if (ph_pulse && pl > 0 && !r1[7]) m_len = pl - 1;

      if (r4_wr) m_flag = 1;
      if (pq) begin
         if (m_flag)       m_lin = int'(r1[6:0]);
         else if (plin > 0) m_lin = plin - 1;
         if (!r1[7]) m_flag = 0;
      end
      m_tri = (pl != 0) && (plin != 0);
      m_act = (pl != 0);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check("outs", {27'd0, qf, hf, irq, len_active, tri_en},
            {27'd0, m_qf, m_hf, m_irq, m_act, m_tri});
      check("length", 32'(dut.length), 32'(m_len));
      check("linear", 32'(dut.linear), 32'(m_lin));
      r4_wr = 0; frame_wr = 0; irq_ack = 0;
   endtask

   typedef struct {
      logic [7:0] r1;
      logic [7:0] r4;
      logic       r4_wr;
      logic [7:0] frame;
      logic       frame_wr;
      logic       chan_en;
      logic [3:0] exp;  // {qf, hf, len_active, tri_en}
   } vec_t;

   vec_t tbl [24];

   initial begin
      tbl[0]  = '{8'h05, 8'h00, 1'b0, 8'h80, 1'b1, 1'b1, 4'b1111};
      tbl[1]  = '{8'h05, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0011};
      tbl[2]  = '{8'h05, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0010};
      tbl[3]  = '{8'h85, 8'h08, 1'b1, 8'h00, 1'b0, 1'b1, 4'b0010};
      tbl[4]  = '{8'h85, 8'h00, 1'b0, 8'h80, 1'b1, 1'b1, 4'b1110};
      tbl[5]  = '{8'h85, 8'h00, 1'b0, 8'h80, 1'b1, 1'b1, 4'b1110};
      for (int i = 6; i <= 13; i++)
         tbl[i] = '{8'h85, 8'h00, 1'b0, 8'h80, 1'b1, 1'b1, 4'b1111};
      tbl[14] = '{8'h85, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0011};
      tbl[15] = '{8'h85, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0011};
      tbl[16] = '{8'h05, 8'h28, 1'b1, 8'h00, 1'b0, 1'b1, 4'b0011};
      tbl[17] = '{8'h05, 8'h00, 1'b0, 8'h80, 1'b1, 1'b1, 4'b1111};
      tbl[18] = '{8'h05, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0011};
      tbl[19] = '{8'h05, 8'h00, 1'b0, 8'h80, 1'b1, 1'b1, 4'b1111};
      tbl[20] = '{8'h05, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 4'b0011};
      tbl[21] = '{8'h05, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0011};
      tbl[22] = '{8'h05, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0000};
      tbl[23] = '{8'h05, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 4'b0000};

      reset = 1; r1 = 0; r4 = 0; frame = 0;
      r4_wr = 0; frame_wr = 0; chan_en = 0; irq_ack = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {27'd0, qf, hf, irq, len_active, tri_en}, 32'd0);

      // Mode 0 from release, with counters loaded, then asynchronous reset mid-frame.
      reset = 0; r1 = 8'h05; chan_en = 1;
      for (int i = 1; i <= 10000; i++) begin
         if (i == 10) begin r4 = 8'h08; r4_wr = 1; end
         cyc();
      end
      #3 reset = 1;
      model_reset();
      #1;
      check("async_reset", {27'd0, qf, hf, irq, len_active, tri_en}, 32'd0);
      check("async_reset_len", 32'(dut.length), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 0;

      // Full mode-0 frame plus the first step of the next one; irq acknowledged after it rises.
      for (int i = 1; i <= 37288; i++) begin
         if (i == 10)    begin r4 = 8'h08; r4_wr = 1; end
         if (i == 29835) irq_ack = 1;
         cyc();
         if (i == P_QF4_M0) check("irq_rise", 32'(irq), 32'(IRQ_FEAT));
         if (i == 29835)    check("irq_ack", 32'(irq), 32'd0);
      end

      for (int i = 0; i < 24; i++) begin
         r1 = tbl[i].r1; r4 = tbl[i].r4; r4_wr = tbl[i].r4_wr;
         frame = tbl[i].frame; frame_wr = tbl[i].frame_wr; chan_en = tbl[i].chan_en;
         cyc();
         check($sformatf("vec%0d", i), {28'd0, qf, hf, len_active, tri_en}, {28'd0, tbl[i].exp});
      end

      // Mode-1 frame under random register traffic.
      frame = 8'h80; frame_wr = 1; chan_en = 1;
      cyc();
      frame = 8'h00;
      for (int i = 1; i <= 37290; i++) begin
         r1      = 8'($urandom);
         r4      = 8'($urandom);
         r4_wr   = ($urandom_range(63) == 0);
         chan_en = ($urandom_range(31) != 0);
         irq_ack = ($urandom_range(15) == 0);
         cyc();
         if (i == P_QF4_M1) check("m1_last_step", {30'd0, qf, hf}, 32'd3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tri_frame_ctrl.md
# tri_frame_ctrl

Frame sequencer and envelope controller for the 2A03 triangle channel. Generates the quarter-frame and half-frame events from the 1.79 MHz CPU clock, runs the triangle linear counter and length counter, and drives a single `tri_en` gate that tells `tri_channel` whether its 32-step sequencer may advance. Sits between the APU register decode and `tri_channel`, in the `clk` domain.

## Interface

Parameters:
- `QF1`, 7457: first quarter-frame step, in CPU clocks.
- `QF2`, 14913: second step, also a half-frame.
- `QF3`, 22371: third step.
- `QF4_M0`, 29829: last step in mode 0, also a half-frame and the IRQ point.
- `QF4_M1`, 37281: last step in mode 1, also a half-frame.

Ports:
- `clk` in 1: 1.79 MHz CPU clock.
- `reset` in 1: asynchronous, active-high.
- `r1` in 8: $4008 value. Bit 7 is control/halt; bits 6:0 are the linear reload value.
- `r4` in 8: $400B value. Bits 7:3 are the length-table index.
- `r4_wr` in 1: one-cycle strobe, $400B written.
- `frame` in 8: $4017 value. Bit 7 is mode (1 = 5-step); bit 6 is IRQ inhibit.
- `frame_wr` in 1: one-cycle strobe, $4017 written.
- `chan_en` in 1: $4015 bit 2, triangle enable.
- `irq_ack` in 1: one-cycle strobe, $4015 read.
- `qf` out 1: quarter-frame pulse.
- `hf` out 1: half-frame pulse.
- `irq` out 1: frame IRQ, level.
- `len_active` out 1: length counter is nonzero.
- `tri_en` out 1: triangle sequencer advance enable.

## Operation

Frame counter:
- `fc` is a 16-bit counter. It increments every clk.
- Mode 0: `fc` wraps to 0 after `QF4_M0`. Mode 1: `fc` wraps to 0 after `QF4_M1`.
- `qf` is asserted at `QF1`, `QF2`, `QF3` and the mode's last step. `hf` is asserted at `QF2` and the last step.
- On `frame_wr`:
  - latch `frame[7:6]`;
  - `fc` ← 0;
  - no decode pulse is produced that cycle;
  - if `frame[7]` = 1, `qf` and `hf` are asserted once immediately (next cycle).
- If `frame[6]` = 1, `irq` is cleared.

IRQ:
- Set at `QF4_M0` in mode 0 when inhibit = 0.
- Held until `irq_ack`, or until a `frame_wr` with bit 6 = 1.
- If a set and a clear occur in the same cycle, the set wins.

Length counter (8-bit):
- On `r4_wr` with `chan_en` = 1: load `LEN_TABLE[r4[7:3]]`.
- On `hf` with no load that cycle: decrement if nonzero and `r1[7]` = 0.
- `chan_en` = 0 forces the counter to 0 and ignores loads.
- A load wins over a simultaneous decrement.

Linear counter (7-bit) and reload flag:
- `r4_wr` sets the reload flag.
- On `qf`, if the flag is set, the counter ← `r1[6:0]`; otherwise the counter decrements if nonzero. After that, if `r1[7]` = 0, the flag is cleared.
- If `r4_wr` and `qf` coincide, the flag is set first and the reload happens on that `qf`.

Outputs:
- `tri_en` = (length ≠ 0) && (linear ≠ 0).
- `len_active` = (length ≠ 0).

## Timing

- Every output is registered.
- Reset values:
  - `fc` = 0; mode = 0; inhibit = 0;
  - `qf`, `hf`, `irq` = 0;
  - length = 0, linear = 0, reload flag = 0;
  - `tri_en` = 0, `len_active` = 0.
- `qf` and `hf` are high for exactly one clk, in the cycle after the edge that loads `fc` with the step value.
- Counters act on the edge that ends the `qf`/`hf` pulse. `tri_en` reflects the new counts one clk later.
- Mode 0 period: 29830 clk. Mode 1 period: 37282 clk.
- Step times in the Interface section are measured from the reset deassertion edge, or from the `frame_wr` edge.
- `irq` rises in the same cycle as the final `qf` of mode 0.
- Length and linear loads are visible on the outputs 1 clk after the strobe edge.
- Reset asserted mid-frame takes effect immediately, asynchronously. Counting restarts from 0 at the first edge after release.

## Configuration

- `TRI_FRAME_IRQ_EN` defined:
  - IRQ flag, inhibit bit and `irq_ack` logic are present as described above.
- `TRI_FRAME_IRQ_EN` not defined:
  - `irq` is tied to 0;
  - `frame[6]` and `irq_ack` are ignored;
  - no IRQ flop is synthesized.

## Structure

- Package `apu_pkg`:
  - `LEN_TABLE` (32×8) = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30;
  - step constants;
  - frame mode typedef (`MODE_4STEP`, `MODE_5STEP`).
- Sub-module `apu_frame_counter`: the `fc` counter, step decode, `qf`/`hf` pulses and IRQ. It is reusable by the pulse and noise channels.

## Test plan

- Release reset, no writes → `qf` pulses at 7457, 14913, 22371, 29829 and `hf` at 14913, 29829; `irq` rises at 29829; the frame repeats with a period of 29830.
- `frame_wr` with `frame` = 8'h80 at cycle 1000 → `qf` and `hf` asserted on the next cycle; subsequent steps at +7457, +14913, +22371, +37281; `irq` never set.
- `r1` = 8'h05, `chan_en` = 1, `r4_wr` with `r4` = 8'h08 (length 254) → after the first `qf` linear = 5 and `tri_en` = 1; after 5 more `qf` linear = 0 and `tri_en` = 0.
- `r1` = 8'h85 (halt) → linear reloads on every `qf` and stays 5; length stays 254 across 10 `hf` pulses.
- `r4_wr` coinciding with an `hf` pulse while length = 3 → length = `LEN_TABLE[idx]`, not 2; then `chan_en` = 0 → length = 0 and `len_active` = 0 next cycle.
- Mode 0 `irq` set, then `irq_ack` → `irq` = 0 next cycle; `reset` pulse at `fc` = 20000 → all outputs 0, next `qf` at 7457 after release.
